// File: rtl/pkg_system_mdr.sv
// Shared MDR datapath types and constants for the BCD-to-binary converter.
package pkg_system_mdr;

    localparam int unsigned MDR_DIGITS = 4;
    localparam int unsigned MDR_BIN_W  = 14;

    localparam logic [3:0] MDR_SUB_CONST  = 4'd3;
    localparam logic [3:0] MDR_SUB_THRESH = 4'd8;
    localparam logic [3:0] MDR_DIGIT_MAX  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } mdr_state_e;

    // Working register: BCD digits on top shift down into the binary part.
    typedef struct packed {
        logic [4*MDR_DIGITS-1:0] bcd_part;
        logic [MDR_BIN_W-1:0]    bin_part;
    } mdr_work_t;

endpackage

// File: rtl/bcd_to_bin_if.sv
// Start/done request bus between a requester and the BCD-to-binary converter.
interface bcd_to_bin_if
    import pkg_system_mdr::*;
#(
    parameter int unsigned DIGITS = MDR_DIGITS,
    parameter int unsigned BIN_W  = MDR_BIN_W
) ();

    logic                  i_start;
    logic [4*DIGITS-1:0]   i_bcd;
    logic [BIN_W-1:0]      o_bin;
    logic                  o_done;
    logic                  o_busy;
    logic                  o_err;

    modport master (
        output i_start, i_bcd,
        input  o_bin, o_done, o_busy, o_err
    );

    modport slave (
        input  i_start, i_bcd,
        output o_bin, o_done, o_busy, o_err
    );

endinterface

// File: rtl/sub_con.sv
// Per-digit correction for reverse double-dabble: subtract 3 from digits >= 8.
module sub_con
    import pkg_system_mdr::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= MDR_SUB_THRESH) begin
            digit_o = digit_i - MDR_SUB_CONST;
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), fixed latency of
// BIN_W shift cycles plus one completion cycle.
module bcd_to_bin
    import pkg_system_mdr::*;
#(
    parameter int unsigned DIGITS = MDR_DIGITS,
    parameter int unsigned BIN_W  = MDR_BIN_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    bcd_to_bin_if.slave  bus
);

    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam int unsigned WORK_W = $bits(mdr_work_t);

    mdr_state_e          state_q;
    mdr_work_t           work_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
    logic [BIN_W-1:0]    bin_q;
    logic                done_q;
    logic                busy_q;
    logic                err_out_q;

    mdr_work_t           shifted_c;
    mdr_work_t           work_d;
    logic [4*DIGITS-1:0] corr_c;
    logic                bad_digit_c;
    logic                accept_c;

    // Shift first; the correction then sees the digits that just moved down.
    assign shifted_c = mdr_work_t'({1'b0, work_q[WORK_W-1:1]});

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        sub_con u_sub_con (
            .digit_i (shifted_c.bcd_part[4*g +: 4]),
            .digit_o (corr_c[4*g +: 4])
        );
    end

    always_comb begin
        work_d          = shifted_c;
        work_d.bcd_part = corr_c;
    end

    always_comb begin
        bad_digit_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.i_bcd[4*i +: 4] > MDR_DIGIT_MAX) begin
                bad_digit_c = 1'b1;
            end
        end
    end

    assign accept_c = bus.i_start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            bin_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: ;
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    bin_q     <= err_q ? '0 : work_q.bin_part;
                    err_out_q <= err_q;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // A new request (from IDLE or the DONE cycle) overrides the state update.
            if (accept_c) begin
                work_q  <= '{bcd_part: bus.i_bcd, bin_part: '0};
                cnt_q   <= '0;
                err_q   <= bad_digit_c;
                busy_q  <= 1'b1;
                state_q <= SHIFT;
            end
        end
    end

    assign bus.o_bin  = bin_q;
    assign bus.o_done = done_q;
    assign bus.o_busy = busy_q;
    assign bus.o_err  = err_out_q;

endmodule
